// File: rtl/led_band_fc_chain_setter.sv
// FC writer for a daisy chain of TLC5957 drivers: deserialises FC frames from the bit-serial link,
// then issues the WREN LAT command, shifts the chain image out and issues the FC-write LAT command.
module led_band_fc_chain_setter #(
  parameter int unsigned N_DRIVERS = 4,
  parameter int unsigned FC_WIDTH  = 48,
  parameter int unsigned BROADCAST = 0,
  parameter int unsigned SCLK_DIV  = 5,
  parameter int unsigned WREN_CYC  = 15,
  parameter int unsigned LAT_WR    = 5,
  parameter int unsigned IDLE_TMO  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spi_clk,
  input  logic                          spi_data,
  output logic                          SCLK,
  output logic                          SOUT,
  output logic                          LAT,
  output logic                          en,
  output logic                          done,
  output logic [N_DRIVERS*FC_WIDTH-1:0] fc
);
  localparam int unsigned NW        = N_DRIVERS * FC_WIDTH;
  localparam int unsigned FL        = (BROADCAST != 0) ? FC_WIDTH : NW;
  localparam int unsigned BW        = $clog2(FL + 1);
  localparam int unsigned TW        = $clog2(IDLE_TMO + 1);
  localparam int unsigned DW        = $clog2(SCLK_DIV + 1);
  localparam int unsigned PMAX      = (NW > WREN_CYC) ? NW : WREN_CYC;
  localparam int unsigned PW        = $clog2(PMAX + 1);
  localparam int unsigned LAT_START = (LAT_WR >= NW) ? 0 : NW - LAT_WR;

  typedef enum logic [2:0] {ST_IDLE, ST_WREN, ST_GAP, ST_SHIFT, ST_FINISH} state_e;

  logic          spi_clk_meta_q, spi_clk_sync_q, spi_clk_prev_q;
  logic          spi_data_meta_q, spi_data_sync_q;
  logic [FL-1:0] in_sr_q, in_sr_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NW-1:0] fc_q, fc_d;
  logic          pending_q, pending_d;
  state_e        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [NW-1:0] out_sr_q, out_sr_d;
  logic          sclk_q, sclk_d, sout_q, sout_d, lat_q, lat_d;
  logic          en_q, en_d, done_q, done_d;
  logic          spi_rise, take, period_end;
  logic [FL-1:0] in_shift;
  logic [NW-1:0] commit_word;

  assign spi_rise = spi_clk_sync_q & ~spi_clk_prev_q;
  assign in_shift = FL'({in_sr_q, spi_data_sync_q});

  // Broadcast frames carry one driver word that is copied into every chain slot.
  if (BROADCAST != 0) begin : g_bcast
    assign commit_word = {N_DRIVERS{in_shift[FC_WIDTH-1:0]}};
  end else begin : g_chain
    assign commit_word = NW'(in_shift);
  end

  // Input deserialiser, frame commit and partial-frame timeout.
  always_comb begin
    in_sr_d   = in_sr_q;
    bit_cnt_d = bit_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    fc_d      = fc_q;
    pending_d = pending_q;
    if (take) pending_d = 1'b0;
    if (spi_rise) begin
      in_sr_d   = in_shift;
      tmo_cnt_d = '0;
      if (bit_cnt_q == BW'(FL - 1)) begin
        bit_cnt_d = '0;
        fc_d      = commit_word;
        pending_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end else if (bit_cnt_q != '0) begin
      if (tmo_cnt_q == TW'(IDLE_TMO - 1)) begin
        bit_cnt_d = '0;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Output sequencer; SOUT/LAT only move at SCLK fall (period end) or on entry with SCLK low.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    per_cnt_d  = per_cnt_q;
    out_sr_d   = out_sr_q;
    sclk_d     = sclk_q;
    sout_d     = sout_q;
    lat_d      = lat_q;
    en_d       = en_q;
    done_d     = 1'b0;
    take       = 1'b0;
    period_end = 1'b0;
    if (state_q != ST_IDLE) begin
      if (div_cnt_q == DW'(SCLK_DIV - 1)) begin
        div_cnt_d  = '0;
        sclk_d     = ~sclk_q;
        period_end = sclk_q;
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
      end
    end
    case (state_q)
      ST_IDLE: begin
        sclk_d    = 1'b0;
        sout_d    = 1'b0;
        lat_d     = 1'b0;
        en_d      = 1'b0;
        div_cnt_d = '0;
        per_cnt_d = '0;
        if (pending_q) begin
          take     = 1'b1;
          out_sr_d = fc_q;
          en_d     = 1'b1;
          lat_d    = 1'b1;
          state_d  = ST_WREN;
        end
      end
      ST_WREN: begin
        if (period_end) begin
          if (per_cnt_q == PW'(WREN_CYC - 1)) begin
            state_d   = ST_GAP;
            lat_d     = 1'b0;
            per_cnt_d = '0;
          end else begin
            per_cnt_d = per_cnt_q + PW'(1);
          end
        end
      end
      ST_GAP: begin
        if (period_end) begin
          if (per_cnt_q == PW'(1)) begin
            state_d   = ST_SHIFT;
            per_cnt_d = '0;
            sout_d    = out_sr_q[NW-1];
            out_sr_d  = NW'({out_sr_q, 1'b0});
            lat_d     = (LAT_START == 0);
          end else begin
            per_cnt_d = per_cnt_q + PW'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (period_end) begin
          if (per_cnt_q == PW'(NW - 1)) begin
            state_d   = ST_FINISH;
            per_cnt_d = '0;
            sout_d    = 1'b0;
            lat_d     = 1'b0;
          end else begin
            per_cnt_d = per_cnt_q + PW'(1);
            sout_d    = out_sr_q[NW-1];
            out_sr_d  = NW'({out_sr_q, 1'b0});
            lat_d     = ((per_cnt_q + PW'(1)) >= PW'(LAT_START));
          end
        end
      end
      ST_FINISH: begin
        if (period_end) begin
          if (per_cnt_q == PW'(1)) begin
            state_d   = ST_IDLE;
            per_cnt_d = '0;
            div_cnt_d = '0;
            sclk_d    = 1'b0;
            en_d      = 1'b0;
            done_d    = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_clk_meta_q  <= 1'b0;
      spi_clk_sync_q  <= 1'b0;
      spi_clk_prev_q  <= 1'b0;
      spi_data_meta_q <= 1'b0;
      spi_data_sync_q <= 1'b0;
      in_sr_q         <= '0;
      bit_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      fc_q            <= '0;
      pending_q       <= 1'b0;
      state_q         <= ST_IDLE;
      div_cnt_q       <= '0;
      per_cnt_q       <= '0;
      out_sr_q        <= '0;
      sclk_q          <= 1'b0;
      sout_q          <= 1'b0;
      lat_q           <= 1'b0;
      en_q            <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      spi_clk_meta_q  <= spi_clk;
      spi_clk_sync_q  <= spi_clk_meta_q;
      spi_clk_prev_q  <= spi_clk_sync_q;
      spi_data_meta_q <= spi_data;
      spi_data_sync_q <= spi_data_meta_q;
      in_sr_q         <= in_sr_d;
      bit_cnt_q       <= bit_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      fc_q            <= fc_d;
      pending_q       <= pending_d;
      state_q         <= state_d;
      div_cnt_q       <= div_cnt_d;
      per_cnt_q       <= per_cnt_d;
      out_sr_q        <= out_sr_d;
      sclk_q          <= sclk_d;
      sout_q          <= sout_d;
      lat_q           <= lat_d;
      en_q            <= en_d;
      done_q          <= done_d;
    end
  end

  assign SCLK = sclk_q;
  assign SOUT = sout_q;
  assign LAT  = lat_q;
  assign en   = en_q;
  assign done = done_q;
  assign fc   = fc_q;

endmodule

// File: tb/tb_led_band_fc_chain_setter.sv
// Bench for led_band_fc_chain_setter: a chained (dut_a) and a broadcast (dut_b) instance, each
// feeding a behavioural 4-driver TLC5957 chain that decodes LAT commands by SCLK count.
module tb_led_band_fc_chain_setter;
  localparam int unsigned W  = 48;
  localparam int unsigned NW = 4 * W;
  localparam int unsigned SEQ_RISES = 15 + 2 + NW + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_spi_clk, a_spi_data, a_sclk, a_sout, a_lat, a_en, a_done;
  logic b_spi_clk, b_spi_data, b_sclk, b_sout, b_lat, b_en, b_done;
  logic [NW-1:0] a_fc, b_fc;

  led_band_fc_chain_setter #(.N_DRIVERS(4), .FC_WIDTH(W), .BROADCAST(0), .SCLK_DIV(5),
    .WREN_CYC(15), .LAT_WR(5), .IDLE_TMO(1024)) dut_a (
    .clk(clk), .rst(rst), .spi_clk(a_spi_clk), .spi_data(a_spi_data), .SCLK(a_sclk),
    .SOUT(a_sout), .LAT(a_lat), .en(a_en), .done(a_done), .fc(a_fc));

  led_band_fc_chain_setter #(.N_DRIVERS(4), .FC_WIDTH(W), .BROADCAST(1), .SCLK_DIV(5),
    .WREN_CYC(15), .LAT_WR(5), .IDLE_TMO(1024)) dut_b (
    .clk(clk), .rst(rst), .spi_clk(b_spi_clk), .spi_data(b_spi_data), .SCLK(b_sclk),
    .SOUT(b_sout), .LAT(b_lat), .en(b_en), .done(b_done), .fc(b_fc));

  // Driver chain models: driver k holds chain[k*W +: W]; driver 0 is nearest SOUT.
  logic [NW-1:0] a_chain = '0, a_latch = '0, b_chain = '0, b_latch = '0;
  bit a_wren = 1'b0, b_wren = 1'b0;
  int a_latcnt = 0, b_latcnt = 0, a_rises = 0, b_rises = 0;
  int a_done_cnt = 0, b_done_cnt = 0;
  int a_lathist[$];
  int b_lathist[$];

  always @(posedge a_sclk) begin
    a_chain = {a_chain[NW-2:0], a_sout};
    a_rises++;
    if (a_lat) a_latcnt++;
  end
  always @(negedge a_lat) begin
    a_lathist.push_back(a_latcnt);
    if (a_latcnt == 15) a_wren = 1'b1;
    else if (a_latcnt == 5 && a_wren) begin a_latch = a_chain; a_wren = 1'b0; end
    a_latcnt = 0;
  end
  always @(posedge b_sclk) begin
    b_chain = {b_chain[NW-2:0], b_sout};
    b_rises++;
    if (b_lat) b_latcnt++;
  end
  always @(negedge b_lat) begin
    b_lathist.push_back(b_latcnt);
    if (b_latcnt == 15) b_wren = 1'b1;
    else if (b_latcnt == 5 && b_wren) begin b_latch = b_chain; b_wren = 1'b0; end
    b_latcnt = 0;
  end
  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input bit sel, input int n, input logic [NW-1:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      if (sel) b_spi_data = bits[i]; else a_spi_data = bits[i];
      repeat (4) @(negedge clk);
      if (sel) b_spi_clk = 1'b1; else a_spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      if (sel) b_spi_clk = 1'b0; else a_spi_clk = 1'b0;
    end
  endtask

  task automatic wait_done(input bit sel, input int target, input string nm);
    int n;
    n = 0;
    while (((sel ? b_done_cnt : a_done_cnt) < target) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, NW'(sel ? b_done_cnt : a_done_cnt), NW'(target));
  endtask

  task automatic wait_wren_a(input string nm);
    int n;
    n = 0;
    while (a_lathist.size() < 1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, NW'(a_lathist.size()), NW'(1));
  endtask

  task automatic run_frame(input bit sel, input int n, input logic [NW-1:0] f, input string nm);
    int base;
    base = sel ? b_done_cnt : a_done_cnt;
    if (sel) begin b_lathist.delete(); b_rises = 0; end
    else begin a_lathist.delete(); a_rises = 0; end
    send(sel, n, f);
    wait_done(sel, base + 1, {nm, "_done"});
    repeat (60) @(negedge clk);
    chk({nm, "_done_once"}, NW'(sel ? b_done_cnt : a_done_cnt), NW'(base + 1));
  endtask

  typedef struct {
    logic [NW-1:0] frame;
    logic [W-1:0]  d0, d1, d2, d3;
  } vec_t;
  vec_t vecs [3];

  logic [NW-1:0] f, fa, fb, fcc;
  logic [W-1:0]  bw;
  int            base;

  initial begin
    vecs[0] = '{frame: {144'h0, 48'hec020100804e},
                d0: 48'hec020100804e, d1: 48'h0, d2: 48'h0, d3: 48'h0};
    vecs[1] = '{frame: {96'h0, 48'h111111111111, 48'hec020100804e},
                d0: 48'hec020100804e, d1: 48'h111111111111, d2: 48'h0, d3: 48'h0};
    vecs[2] = '{frame: {48'hdeadbeefcafe, 48'h123456789abc, 48'hfedcba987654, 48'h000000000001},
                d0: 48'h000000000001, d1: 48'hfedcba987654, d2: 48'h123456789abc,
                d3: 48'hdeadbeefcafe};

    rst = 1'b1;
    a_spi_clk = 1'b0; a_spi_data = 1'b0; b_spi_clk = 1'b0; b_spi_data = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_a_outs", NW'({a_sclk, a_sout, a_lat, a_en, a_done}), '0);
    chk("rst_a_fc", a_fc, '0);
    chk("rst_b_outs", NW'({b_sclk, b_sout, b_lat, b_en, b_done}), '0);
    chk("rst_b_fc", b_fc, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Chained frames from the table.
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b0, NW, vecs[i].frame, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_fc", i), a_fc, vecs[i].frame);
      chk($sformatf("vec%0d_drv0", i), NW'(a_latch[0*W +: W]), NW'(vecs[i].d0));
      chk($sformatf("vec%0d_drv1", i), NW'(a_latch[1*W +: W]), NW'(vecs[i].d1));
      chk($sformatf("vec%0d_drv2", i), NW'(a_latch[2*W +: W]), NW'(vecs[i].d2));
      chk($sformatf("vec%0d_drv3", i), NW'(a_latch[3*W +: W]), NW'(vecs[i].d3));
      chk($sformatf("vec%0d_sclks", i), NW'(a_rises), NW'(SEQ_RISES));
      chk($sformatf("vec%0d_latcmds", i), NW'(a_lathist.size()), NW'(2));
      if (a_lathist.size() == 2) begin
        chk($sformatf("vec%0d_wren_len", i), NW'(a_lathist[0]), NW'(15));
        chk($sformatf("vec%0d_wr_len", i), NW'(a_lathist[1]), NW'(5));
      end
    end

    // Random chained frames: driver k must latch frame bits [k*W +: W].
    for (int r = 0; r < 3; r++) begin
      f = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      run_frame(1'b0, NW, f, $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_fc", r), a_fc, f);
      for (int k = 0; k < 4; k++)
        chk($sformatf("rnd%0d_drv%0d", r, k), NW'(a_latch[k*W +: W]), NW'(f[k*W +: W]));
    end

    // Broadcast word reaches all four drivers with a full 192-bit shift.
    bw = 48'h0a0b0c0d0e0f;
    run_frame(1'b1, W, NW'(bw), "bcast");
    chk("bcast_fc", b_fc, {4{bw}});
    for (int k = 0; k < 4; k++)
      chk($sformatf("bcast_drv%0d", k), NW'(b_latch[k*W +: W]), NW'(bw));
    chk("bcast_sclks", NW'(b_rises), NW'(SEQ_RISES));

    // Partial frame discarded by the idle timeout, then a clean frame.
    base = b_done_cnt;
    send(1'b1, 20, NW'(20'habcde));
    repeat (1100) @(negedge clk);
    chk("tmo_no_commit", NW'(b_done_cnt + (b_en ? 1 : 0)), NW'(base));
    bw = 48'hec020100804e;
    run_frame(1'b1, W, NW'(bw), "tmo");
    chk("tmo_fc", b_fc, {4{bw}});
    for (int k = 0; k < 4; k++)
      chk($sformatf("tmo_drv%0d", k), NW'(b_latch[k*W +: W]), NW'(bw));

    // Frame B committed during SHIFT of frame A: A written first, B follows back-to-back.
    fa = {48'haaaa00000001, 48'haaaa00000002, 48'haaaa00000003, 48'haaaa00000004};
    fb = {48'hbbbb00000001, 48'hbbbb00000002, 48'hbbbb00000003, 48'hbbbb00000004};
    base = a_done_cnt;
    a_lathist.delete();
    send(1'b0, NW, fa);
    wait_wren_a("b2b_wren");
    send(1'b0, NW, fb);
    wait_done(1'b0, base + 1, "b2b_done1");
    chk("b2b_latch_a", a_latch, fa);
    chk("b2b_fc_b", a_fc, fb);
    wait_done(1'b0, base + 2, "b2b_done2");
    chk("b2b_latch_b", a_latch, fb);
    repeat (100) @(negedge clk);
    chk("b2b_done_twice", NW'(a_done_cnt), NW'(base + 2));

    // One-cycle reset in the middle of SHIFT aborts without touching the driver latches.
    fcc = {48'hcccc00000001, 48'hcccc00000002, 48'hcccc00000003, 48'hcccc00000004};
    base = a_done_cnt;
    a_lathist.delete();
    send(1'b0, NW, fcc);
    wait_wren_a("abort_wren");
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outs", NW'({a_sclk, a_sout, a_lat, a_en, a_done}), '0);
    chk("abort_fc", a_fc, '0);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    chk("abort_no_done", NW'(a_done_cnt), NW'(base));
    chk("abort_latch_kept", a_latch, fb);
    chk("abort_idle", NW'({a_sclk, a_lat, a_en}), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
